// File: rtl/score_pkg.sv
// Shared constants and state encoding for the score BCD converter.
// Sized for a full 32-bit unsigned input.
package score_pkg;

    localparam int unsigned NUM_DIGITS_DEFAULT = 8;
    localparam int unsigned BCD_WIDTH          = 40;
    localparam int unsigned BCD_DIGITS         = BCD_WIDTH / 4;
    localparam int unsigned BIN_WIDTH          = 32;
    localparam int unsigned SHIFT_COUNT        = 32;
    localparam int unsigned CNT_W              = $clog2(SHIFT_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble correction step: every BCD nibble >= 5 gets 3 added
// so that the following left shift carries correctly into the next decade.
module bcd_adjust
    import score_pkg::*;
(
    input  logic [BCD_WIDTH-1:0] bcd_in,
    output logic [BCD_WIDTH-1:0] bcd_out
);

    always_comb begin
        bcd_out = bcd_in;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter for the score display: one double-dabble
// step per clock, results held in registers until the next completion.
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    start,
    input  logic [31:0]             value,
    input  logic [3:0]              digit_sel,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    overflow,
    output logic [3:0]              digit_out
);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]      bin_q, bin_d;
    logic [BCD_WIDTH-1:0]      bcd_q, bcd_d;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic                      ovf_q, ovf_d;

    logic [BCD_WIDTH-1:0]           bcd_adj;
    logic [BCD_WIDTH+BIN_WIDTH-1:0] shift_v;

    bcd_adjust u_bcd_adjust (
        .bcd_in  (bcd_q),
        .bcd_out (bcd_adj)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        shift_v  = {bcd_adj, bin_q} << 1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = shift_v;
                cnt_d          = cnt_q + 1'b1;
                // Results are captured from the final shift, on the edge entering DONE.
                if (cnt_q == CNT_W'(SHIFT_COUNT - 1)) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        digits_d[4*i +: 4] = (i < BCD_DIGITS) ? bcd_d[4*i +: 4] : 4'h0;
                    end
                    for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
                        ovf_d = ovf_d | (|bcd_d[4*i +: 4]);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        digit_out = 4'hF;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel == 4'(i)) begin
                digit_out = digits_q[4*i +: 4];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign digits   = digits_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed self-checking bench for score_bcd_converter (NUM_DIGITS = 8).
// Outputs are sampled on the falling edge; "edge e" is the e-th rising edge after the accepting edge.
module tb_score_bcd_converter;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [31:0] value;
    logic [3:0]  digit_sel;
    logic        busy;
    logic        done;
    logic [31:0] digits;
    logic        overflow;
    logic [3:0]  digit_out;

    int n_checks = 0;
    int n_pass   = 0;

    score_bcd_converter #(.NUM_DIGITS(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .value     (value),
        .digit_sel (digit_sel),
        .busy      (busy),
        .done      (done),
        .digits    (digits),
        .overflow  (overflow),
        .digit_out (digit_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Must be entered at a falling edge; start is presented for the next rising edge.
    // Optionally re-asserts start with inj_val just before edge inj_cyc.
    task automatic conv_check(input string tag, input logic [31:0] v, input int inj_cyc,
                              input logic [31:0] inj_val, input logic [31:0] prev,
                              input logic [31:0] exp_digits, input logic exp_ovf);
        int first_done = -1;
        int pulses     = 0;
        logic busy_ok  = 1'b1;
        logic held_ok  = 1'b1;
        logic idle_ok  = 1'b1;
        start = 1'b1;
        value = v;
        @(posedge Clk);
        for (int e = 1; e <= 36; e++) begin
            @(negedge Clk);
            start = (e == inj_cyc);
            value = (e == inj_cyc) ? inj_val : 32'd0;
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = e;
            end
            if (e <= 33 && !busy) busy_ok = 1'b0;
            if (e == 34 && busy) idle_ok = 1'b0;
            if (e <= 32 && digits !== prev) held_ok = 1'b0;
            @(posedge Clk);
        end
        @(negedge Clk);
        start = 1'b0;
        check({tag, "_done_edge"}, 64'(first_done), 64'd33);
        check({tag, "_done_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_busy_span"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_idle_after"}, {63'd0, idle_ok}, 64'd1);
        check({tag, "_digits_held"}, {63'd0, held_ok}, 64'd1);
        check({tag, "_digits"}, {32'd0, digits}, {32'd0, exp_digits});
        check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, exp_ovf});
    endtask

    initial begin
        int waited;
        int stray;
        Reset     = 1'b1;
        start     = 1'b0;
        value     = 32'd0;
        digit_sel = 4'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_digits", {32'd0, digits}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_digit_out", {60'd0, digit_out}, 64'd0);

        // Start presented together with reset release: accepted on the very next edge.
        Reset = 1'b0;
        conv_check("zero", 32'd0, 0, 32'd0, 32'h0, 32'h00000000, 1'b0);

        conv_check("v1234", 32'd1234, 0, 32'd0, 32'h0, 32'h00001234, 1'b0);
        digit_sel = 4'd2; #1 check("sel2", {60'd0, digit_out}, 64'd2);
        digit_sel = 4'd0; #1 check("sel0", {60'd0, digit_out}, 64'd4);
        digit_sel = 4'd7; #1 check("sel7", {60'd0, digit_out}, 64'd0);
        digit_sel = 4'd8; #1 check("sel8", {60'd0, digit_out}, 64'hF);
        digit_sel = 4'd9; #1 check("sel9", {60'd0, digit_out}, 64'hF);
        @(negedge Clk);

        conv_check("v99999999", 32'd99999999, 0, 32'd0, 32'h00001234, 32'h99999999, 1'b0);
        digit_sel = 4'd7; #1 check("sel7_nines", {60'd0, digit_out}, 64'd9);
        @(negedge Clk);
        conv_check("v100000000", 32'd100000000, 0, 32'd0, 32'h99999999, 32'h00000000, 1'b1);

        // Back-to-back: second start lands on the first IDLE edge (edge 34).
        conv_check("vmax", 32'd4294967295, 34, 32'd20240607, 32'h00000000, 32'h94967295, 1'b1);
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        waited = -1;
        for (int n = 1; n <= 60; n++) begin
            if (done) begin
                waited = n;
                break;
            end
            @(negedge Clk);
        end
        check("b2b_done_wait", 64'(waited), 64'd31);
        @(negedge Clk);
        check("b2b_digits", {32'd0, digits}, {32'd0, 32'h20240607});
        check("b2b_overflow", {63'd0, overflow}, 64'd0);

        conv_check("v42_ignore", 32'd42, 10, 32'd5, 32'h20240607, 32'h00000042, 1'b0);

        // Reset in the middle of a conversion.
        start = 1'b1;
        value = 32'd777;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        value = 32'd0;
        repeat (14) @(negedge Clk);
        check("mid_busy_before", {63'd0, busy}, 64'd1);
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_digits", {32'd0, digits}, 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (done || busy) stray++;
        end
        check("mid_rst_no_done", 64'(stray), 64'd0);
        check("mid_rst_digits_after", {32'd0, digits}, 64'd0);
        conv_check("v777", 32'd777, 0, 32'd0, 32'h00000000, 32'h00000777, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_bcd_converter.md
SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of decimal digits exposed to the score renderer.
REQ-002 SHALL have port Clk, input, 1, sole clock.
REQ-003 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, conversion request; sampled on the rising edge of Clk.
REQ-005 SHALL have port value, input, 32, unsigned binary score; sampled only with an accepted start.
REQ-006 SHALL have port digit_sel, input, 4, digit position (0 = ones) for the read port.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress or completing.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port digits, output, 4*NUM_DIGITS, packed BCD, nibble i = digit i.
REQ-010 SHALL have port overflow, output, 1, set when the converted value exceeds NUM_DIGITS decimal digits.
REQ-011 SHALL have port digit_out, output, 4, combinational read of nibble digit_sel from registered digits.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE; in the accepting cycle: value -> binary shift register, 40-bit BCD accumulator cleared, bit counter = 0, next state SHIFT.
REQ-014 SHALL ignore start in SHIFT and DONE; no restart, no queueing, and value is not resampled.
REQ-015 SHALL, in each SHIFT cycle, add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by one, feeding the binary MSB into the BCD LSB (double dabble).
REQ-016 SHALL perform exactly 32 SHIFT cycles and then enter DONE.
REQ-017 SHALL load digits with BCD[4*NUM_DIGITS-1:0], and overflow with OR of the BCD nibbles above NUM_DIGITS, on the edge that enters DONE.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, 33 clock edges after the start-accepting edge; DONE always returns to IDLE.
REQ-019 SHALL drive busy = (state != IDLE).
REQ-020 SHALL hold digits and overflow unchanged between completions, including throughout a later conversion until its DONE.
REQ-021 SHALL make digit_out = digits nibble digit_sel for digit_sel < NUM_DIGITS, and 4'hF otherwise.
REQ-022 SHALL keep every BCD nibble in 0..9 at all times; the widest input, 4294967295, needs 10 nibbles, so the accumulator SHALL be 40 bits.
REQ-023 SHALL accept a start in the first IDLE cycle after DONE, allowing back-to-back conversions every 34 cycles.

Reset
REQ-024 SHALL, on asynchronous Reset assertion, force state IDLE, counter 0, shift and BCD registers 0, digits 0, overflow 0, done 0 and busy 0.
REQ-025 SHALL, on Reset asserted mid-conversion, abandon the conversion with no done pulse and leave digits at 0.
REQ-026 SHALL accept start on the first rising edge after Reset deasserts.

Structure
REQ-027 SHALL put NUM_DIGITS default, BCD_WIDTH = 40, the state enum, and the shift count 32 in shared package score_pkg.
REQ-028 SHALL instantiate sub-module bcd_adjust (combinational per-nibble add-3-if-≥5 over the 40-bit accumulator); the FSM, counter and registers SHALL remain in score_bcd_converter.

Verification
REQ-029 SHALL cover: start with value=0 -> done at edge +33, digits=32'h00000000, overflow=0.
REQ-030 SHALL cover: value=1234 -> digits=32'h00001234; digit_sel=2 gives digit_out=2; digit_sel=9 gives 4'hF.
REQ-031 SHALL cover: value=99999999 -> digits=32'h99999999, overflow=0; value=100000000 -> digits=32'h00000000, overflow=1.
REQ-032 SHALL cover: value=4294967295 -> digits=32'h94967295, overflow=1.
REQ-033 SHALL cover: start=1 with value=5 at cycle 10 of a conversion of 42 -> ignored; a single done; digits=32'h00000042.
REQ-034 SHALL cover: Reset at cycle 15 of a conversion of 777 -> busy=0 immediately, no done, digits=0; a subsequent start with 777 -> digits=32'h00000777.
